// File: rtl/alu_issue_queue_if.sv
// Issue-queue bus: rename-side enqueue, result-bus wakeup, ALU stall/flush and the issue slot.
interface alu_issue_queue_if #(
   parameter int PAYLOAD_W = 128,
   parameter int NUM_WB    = 2
);
   logic                  IN_valid;
   logic [5:0]            IN_sqN;
   logic [5:0]            IN_tagA;
   logic [5:0]            IN_tagB;
   logic                  IN_availA;
   logic                  IN_availB;
   logic [PAYLOAD_W-1:0]  IN_payload;
   logic                  OUT_full;
   logic [NUM_WB-1:0]     IN_wbValid;
   logic [6*NUM_WB-1:0]   IN_wbTag;
   logic                  IN_stall;
   logic                  IN_invalidate;
   logic [5:0]            IN_invalidateSqN;
   logic                  OUT_valid;
   logic [5:0]            OUT_sqN;
   logic [PAYLOAD_W-1:0]  OUT_payload;

   modport master (
      output IN_valid, IN_sqN, IN_tagA, IN_tagB, IN_availA, IN_availB, IN_payload,
      output IN_wbValid, IN_wbTag, IN_stall, IN_invalidate, IN_invalidateSqN,
      input  OUT_full, OUT_valid, OUT_sqN, OUT_payload
   );

   modport slave (
      input  IN_valid, IN_sqN, IN_tagA, IN_tagB, IN_availA, IN_availB, IN_payload,
      input  IN_wbValid, IN_wbTag, IN_stall, IN_invalidate, IN_invalidateSqN,
      output OUT_full, OUT_valid, OUT_sqN, OUT_payload
   );
endinterface

// File: rtl/alu_issue_queue.sv
// Out-of-order integer issue queue: wakeup by result-bus tags, oldest-ready select
// into a registered issue slot, with stall hold and sequence-number flush.
module alu_issue_queue #(
   parameter int DEPTH     = 8,
   parameter int PAYLOAD_W = 128,
   parameter int NUM_WB    = 2
) (
   input logic             clk,
   input logic             rst,
   alu_issue_queue_if.slave bus
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   logic [DEPTH-1:0]     valid;
   logic [DEPTH-1:0]     rdyA;
   logic [DEPTH-1:0]     rdyB;
   logic [5:0]           sqN     [DEPTH];
   logic [5:0]           tagA    [DEPTH];
   logic [5:0]           tagB    [DEPTH];
   logic [PAYLOAD_W-1:0] payload [DEPTH];
   logic [CW-1:0]        count;

   logic [DEPTH-1:0] effA, effB, kill, cand;
   logic             selFound, issue, freeFound, enqKill, enq, slotKill;
   logic [IW-1:0]    selIdx, freeIdx;
   logic [5:0]       selSq;
   logic [CW-1:0]    killCnt, countNext;

   // a - b as a signed 6-bit difference: positive means a is younger.
   function automatic logic younger(input logic [5:0] a, input logic [5:0] b);
      logic [5:0] d;
      d = a - b;
      return (d != '0) && !d[5];
   endfunction

   function automatic logic older(input logic [5:0] a, input logic [5:0] b);
      logic [5:0] d;
      d = a - b;
      return d[5];
   endfunction

   function automatic logic wbHit(input logic [5:0] tag, input logic [NUM_WB-1:0] v,
                                  input logic [6*NUM_WB-1:0] t);
      logic hit;
      hit = 1'b0;
      for (int unsigned k = 0; k < NUM_WB; k++)
         if (v[k] && (t[6*k +: 6] == tag)) hit = 1'b1;
      return hit;
   endfunction

   always_comb begin
      effA      = '0;
      effB      = '0;
      kill      = '0;
      cand      = '0;
      selFound  = 1'b0;
      selIdx    = '0;
      selSq     = '0;
      freeFound = 1'b0;
      freeIdx   = '0;
      killCnt   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         effA[i] = rdyA[i] | wbHit(tagA[i], bus.IN_wbValid, bus.IN_wbTag);
         effB[i] = rdyB[i] | wbHit(tagB[i], bus.IN_wbValid, bus.IN_wbTag);
         kill[i] = valid[i] && bus.IN_invalidate && younger(sqN[i], bus.IN_invalidateSqN);
         cand[i] = valid[i] && effA[i] && effB[i] && !kill[i];
         killCnt = killCnt + CW'(kill[i]);
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (cand[i] && (!selFound || older(sqN[i], selSq))) begin
            selFound = 1'b1;
            selIdx   = IW'(i);
            selSq    = sqN[i];
         end
      end
      // Free search uses current occupancy only; a slot vacated by this cycle's issue
      // becomes usable next cycle.
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!valid[i] && !freeFound) begin
            freeFound = 1'b1;
            freeIdx   = IW'(i);
         end
      end
      issue     = selFound && !bus.IN_stall;
      enqKill   = bus.IN_invalidate && younger(bus.IN_sqN, bus.IN_invalidateSqN);
      enq       = bus.IN_valid && !bus.OUT_full && freeFound && !enqKill;
      slotKill  = bus.OUT_valid && bus.IN_invalidate && younger(bus.OUT_sqN, bus.IN_invalidateSqN);
      countNext = count + CW'(enq) - CW'(issue) - killCnt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid           <= '0;
         rdyA            <= '0;
         rdyB            <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            sqN[i]     <= '0;
            tagA[i]    <= '0;
            tagB[i]    <= '0;
            payload[i] <= '0;
         end
         count           <= '0;
         bus.OUT_full    <= 1'b0;
         bus.OUT_valid   <= 1'b0;
         bus.OUT_sqN     <= '0;
         bus.OUT_payload <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (kill[i] || (issue && (selIdx == IW'(i)))) begin
               valid[i] <= 1'b0;
            end else if (valid[i]) begin
               rdyA[i] <= effA[i];
               rdyB[i] <= effB[i];
            end
         end
         if (enq) begin
            valid[freeIdx]   <= 1'b1;
            sqN[freeIdx]     <= bus.IN_sqN;
            tagA[freeIdx]    <= bus.IN_tagA;
            tagB[freeIdx]    <= bus.IN_tagB;
            rdyA[freeIdx]    <= bus.IN_availA | wbHit(bus.IN_tagA, bus.IN_wbValid, bus.IN_wbTag);
            rdyB[freeIdx]    <= bus.IN_availB | wbHit(bus.IN_tagB, bus.IN_wbValid, bus.IN_wbTag);
            payload[freeIdx] <= bus.IN_payload;
         end
         count        <= countNext;
         bus.OUT_full <= (countNext >= CW'(DEPTH));
         if (!bus.IN_stall) begin
            bus.OUT_valid <= issue;
            if (issue) begin
               bus.OUT_sqN     <= sqN[selIdx];
               bus.OUT_payload <= payload[selIdx];
            end
         end else if (slotKill) begin
            bus.OUT_valid <= 1'b0;
         end
      end
   end
endmodule
